// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle signed multiply/divide engine driving the HI/LO registers
// Ports: clk, reset (async, active-high); start/op/a/b request an operation
// (op 0 = multiply, 1 = divide); busy/done report progress; hi_out/lo_out carry
// the result (product halves, or remainder/quotient); hi_load/lo_load pulse
// with done; div_by_zero flags a zero divisor and is held with the result.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_load,
  output logic             lo_load,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_mb, r_a, r_hi, r_lo;
  logic r_op, r_neg_a, r_neg_b, r_dz;
  logic [WIDTH:0] w_sum, w_sh, w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo, w_rem;
  logic w_ge, w_last, w_dz;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE) ? (start ? CALC : IDLE) :
             (r_state == CALC) ? (w_last ? DONE : CALC) : IDLE;
  always_comb begin
    busy    = r_state != IDLE;
    done    = r_state == DONE;
    hi_load = r_state == DONE;
    lo_load = r_state == DONE;
  end
  assign hi_out      = r_hi;
  assign lo_out      = r_lo;
  assign div_by_zero = r_dz;
  // r_acc:r_q is the product register for multiply and remainder:quotient for divide;
  // the extra counter state (r_cnt == WIDTH) is the sign-correction edge.
  always_comb begin
    w_last = r_cnt == CW'(WIDTH);
    w_sum  = {1'b0, r_acc} + {1'b0, r_mb};
    w_sh   = {r_acc, r_q[WIDTH-1]};
    w_ge   = w_sh >= {1'b0, r_mb};
    w_diff = w_sh - {1'b0, r_mb};
    w_prod = (r_neg_a ^ r_neg_b) ? -{r_acc, r_q} : {r_acc, r_q};
    w_quo  = (r_neg_a ^ r_neg_b) ? -r_q : r_q;
    w_rem  = r_neg_a ? -r_acc : r_acc;
    w_dz   = r_op && (r_mb == '0);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_mb    <= '0;
      r_a     <= '0;
      r_op    <= 1'b0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dz    <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_op    <= op;
      r_a     <= a;
      r_neg_a <= a[WIDTH-1];
      r_neg_b <= b[WIDTH-1];
      r_acc   <= '0;
      r_q     <= a[WIDTH-1] ? -a : a;
      r_mb    <= b[WIDTH-1] ? -b : b;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
    end else if (r_state == CALC && !w_last) begin
      r_cnt <= r_cnt + CW'(1);
      if (r_op) begin
        r_acc <= w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
        r_q   <= {r_q[WIDTH-2:0], w_ge};
      end else
        {r_acc, r_q} <= r_q[0] ? {w_sum, r_q[WIDTH-1:1]} : {1'b0, r_acc, r_q[WIDTH-1:1]};
    end else if (r_state == CALC) begin
      r_dz <= w_dz;
      r_hi <= r_op ? (w_dz ? r_a : w_rem) : w_prod[2*WIDTH-1:WIDTH];
      r_lo <= r_op ? (w_dz ? '1 : w_quo) : w_prod[WIDTH-1:0];
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and reference-model checks of mul_div_unit timing and results
module tb_mul_div_unit;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, hi_load, lo_load, div_by_zero;
  logic [31:0] hi_out, lo_out;
  int n_vec = 0, n_err = 0, cnt;
  logic [31:0] x, y, ehi, elo;
  logic edz;
  int sx, sy;
  longint p;
  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out),
    .hi_load(hi_load), .lo_load(lo_load), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] xhi, input logic [31:0] xlo, input logic xdz, input bit glitch);
    int early;
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy_start"}, busy, 1);
    chk({tag, ".dz_clear"}, div_by_zero, 0);
    early = 0;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk); #1;
      if (glitch && i == 4) begin
        start = 1'b1; op = ~o; a = 32'd9; b = 32'd9;
      end else start = 1'b0;
      if (i < 33 && (done || hi_load || lo_load || !busy)) early++;
    end
    chk({tag, ".early"}, early, 0);
    chk({tag, ".done"}, {done, hi_load, lo_load, busy}, 4'b1111);
    chk({tag, ".hi"}, hi_out, xhi);
    chk({tag, ".lo"}, lo_out, xlo);
    chk({tag, ".dz"}, div_by_zero, xdz);
    @(posedge clk); #1;
    chk({tag, ".after"}, {done, hi_load, lo_load, busy}, 4'b0000);
    chk({tag, ".hold"}, {hi_out, lo_out}, {xhi, xlo});
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ctl", {busy, done, hi_load, lo_load, div_by_zero}, 5'b0);
    chk("reset.data", {hi_out, lo_out}, 64'd0);
    reset = 1'b0;
    run_op("mul_neg3x5", 1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
    op = 1'b0; a = 32'd7; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort.ctl", {busy, done, hi_load, lo_load, div_by_zero}, 5'b0);
    chk("abort.data", {hi_out, lo_out}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) cnt++;
    end
    chk("abort.no_done", cnt, 0);
    run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0);
    run_op("mul_minxmin", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0, 1'b0);
    run_op("div_neg7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("div_7_neg2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("div_25_0", 1'b1, 32'd25, 32'd0, 32'd25, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b0);
    run_op("div_glitch", 1'b1, 32'd100, 32'd3, 32'd1, 32'd33, 1'b0, 1'b1);
    run_op("mul_zero", 1'b0, 32'd0, 32'h80000000, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 400; k++) begin
      x = $urandom;
      y = $urandom;
      if (k % 4 == 1) y = {{24{y[31]}}, y[31:24]};
      if (k == 3) y = 32'd0;
      sx = x;
      sy = y;
      edz = 1'b0;
      if (k % 2 == 0) begin
        p = longint'(sx) * longint'(sy);
        ehi = p[63:32];
        elo = p[31:0];
      end else if (sy == 0) begin
        ehi = x; elo = 32'hFFFFFFFF; edz = 1'b1;
      end else if (x == 32'h80000000 && sy == -1) begin
        ehi = 32'd0; elo = x;
      end else begin
        elo = sx / sy;
        ehi = sx % sy;
      end
      run_op($sformatf("rnd%0d", k), k[0], x, y, ehi, elo, edz, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
